// File: rtl/catv_periph_uart.sv
// catv_riscv data-bus responder: 8N1 UART transmitter fed by a byte FIFO, plus
// status, baud divisor, scratch RESULT and sticky EXIT registers.
module catv_periph_uart #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd867,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            strb_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  tx_o,
    output logic                  exit_valid_o,
    output logic [31:0]           exit_code_o,
    output logic                  err_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [ADDR_WIDTH-1:0] OffTx     = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] OffStatus = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] OffCtrl   = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] OffResult = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] OffExit   = ADDR_WIDTH'(8'h20);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_div, r_bit_div, r_timer;
    logic [31:0]   r_result, r_exit_code, r_rdata;
    logic          r_exit_valid, r_rvalid, r_err, r_tx;
    state_t        r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;

    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_full, w_empty, w_busy, w_push_req, w_push, w_pop, w_mapped;
    logic [31:0]           w_status, w_rdata;

    assign w_off      = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != StIdle);
    assign w_push_req = valid_i && we_i && (w_off == OffTx) && strb_i[0];
    // No bypass: a full FIFO stalls the push even if the FSM pops this cycle.
    assign ready_o    = valid_i && !(w_push_req && w_full);
    assign w_push     = ready_o && w_push_req;
    assign w_pop      = (r_state == StIdle) && !w_empty;
    assign w_status   = (32'(r_count) << 8) | {29'h0, w_busy, w_empty, w_full};

    always_comb begin
        w_rdata  = 32'hDEAD_BEEF;
        w_mapped = 1'b1;
        case (w_off)
            OffTx:     w_rdata = 32'h0;
            OffStatus: w_rdata = w_status;
            OffCtrl:   w_rdata = {16'h0, r_div};
            OffResult: w_rdata = r_result;
            OffExit:   w_rdata = r_exit_code;
            default:   w_mapped = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid     <= 1'b0;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
            r_div        <= DIV_RESET;
            r_result     <= 32'h0;
            r_exit_code  <= 32'h0;
            r_exit_valid <= 1'b0;
        end else begin
            r_rvalid <= ready_o && !we_i;
            r_err    <= ready_o && !w_mapped;
            if (ready_o && !we_i) begin
                r_rdata <= w_rdata;
            end
            if (ready_o && we_i) begin
                if (w_off == OffCtrl) begin
                    for (int i = 0; i < 2; i++) begin
                        if (strb_i[i]) r_div[8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
                if (w_off == OffResult) begin
                    for (int i = 0; i < 4; i++) begin
                        if (strb_i[i]) r_result[8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
                if (w_off == OffExit) begin
                    r_exit_code  <= wdata_i;
                    r_exit_valid <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; the pointers and count define its validity.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_tx      <= 1'b1;
            r_shift   <= 8'h0;
            r_bit_div <= 16'h0;
            r_timer   <= 16'h0;
            r_bit_idx <= 3'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rptr];
                        r_bit_div <= r_div;
                        r_timer   <= r_div;
                        r_tx      <= 1'b0;
                        r_state   <= StStart;
                    end
                end
                StStart: begin
                    if (r_timer == 16'h0) begin
                        r_timer   <= r_bit_div;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= StData;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                StData: begin
                    if (r_timer == 16'h0) begin
                        r_timer <= r_bit_div;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                StStop: begin
                    if (r_timer == 16'h0) r_state <= StIdle;
                    else                  r_timer <= r_timer - 16'd1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rvalid_o     = r_rvalid;
    assign rdata_o      = r_rdata;
    assign tx_o         = r_tx;
    assign exit_valid_o = r_exit_valid;
    assign exit_code_o  = r_exit_code;
    assign err_o        = r_err;
endmodule

// File: tb/tb_catv_periph_uart.sv
// Directed bench for catv_periph_uart: read responses checked against a queue of
// expected data and latency; UART line, stalls, exit and error outputs checked inline.
module tb_catv_periph_uart;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  addr_i;
    logic        we_i;
    logic [3:0]  strb_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        tx_o;
    logic        exit_valid_o;
    logic [31:0] exit_code_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       tag;
    } exp_t;
    exp_t sb[$];

    catv_periph_uart #(
        .FIFO_DEPTH(8),
        .DIV_RESET (16'd867),
        .ADDR_WIDTH(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .strb_i      (strb_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .tx_o        (tx_o),
        .exit_valid_o(exit_valid_o),
        .exit_code_o (exit_code_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every read response must match the oldest queued expectation, one cycle later.
    always @(posedge clk_i) begin : mon
        exp_t e;
        #2;
        if (rvalid_o) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'(rvalid_o), 32'h0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_data"}, rdata_o, e.data);
                chk({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
            end
        end
    end

    task automatic bus_op(input logic we, input logic [7:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd, input logic [31:0] rexp, input string tag,
                          output int stalls, output int stamp);
        exp_t e;
        @(negedge clk_i);
        valid_i = 1'b1;
        we_i    = we;
        addr_i  = addr;
        strb_i  = strb;
        wdata_i = wd;
        stalls  = 0;
        #1;
        while (!ready_o && stalls < 5000) begin
            @(negedge clk_i);
            #1;
            stalls++;
        end
        stamp = cyc;
        if (!ready_o) begin
            chk({tag, "_ready_timeout"}, 32'(ready_o), 32'h1);
            valid_i = 1'b0;
            return;
        end
        if (!we) begin
            e.data = rexp;
            e.cyc  = cyc;
            e.tag  = tag;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                      input string tag);
        int s, t;
        bus_op(1'b1, addr, strb, wd, 32'h0, tag, s, t);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] rexp, input string tag);
        int s, t;
        bus_op(1'b0, addr, 4'h0, 32'h0, rexp, tag, s, t);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [7:0] byte_v;
        logic       exp_tx;
        int         st, stamp0, stamp10;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        we_i    = 1'b0;
        addr_i  = 8'h0;
        strb_i  = 4'h0;
        wdata_i = 32'h0;
        #12;
        chk("rst_ready", 32'(ready_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_tx", 32'(tx_o), 32'h1);
        chk("rst_exit_valid", 32'(exit_valid_o), 32'h0);
        chk("rst_exit_code", exit_code_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd(8'h04, 32'h0000_0002, "rst_status");
        rd(8'h08, 32'h0000_0363, "rst_ctrl");
        rd(8'h10, 32'h0000_0000, "rst_result");

        // 0x41 at 4 cycles per bit, framed after one idle cycle
        wr(8'h08, 4'b0011, 32'h0000_0003, "ctrl3");
        wr(8'h00, 4'b0001, 32'h0000_0041, "tx41");
        chk("tx_idle_cycle", 32'(tx_o), 32'h1);
        byte_v = 8'h41;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) rd(8'h04, 32'h0000_0006, "status_busy");
            else begin
                @(posedge clk_i);
                #1;
            end
            if (i / 4 == 0)      exp_tx = 1'b0;
            else if (i / 4 == 9) exp_tx = 1'b1;
            else                 exp_tx = byte_v[i/4 - 1];
            chk($sformatf("tx_bit%0d", i), 32'(tx_o), 32'(exp_tx));
        end
        @(posedge clk_i);
        rd(8'h04, 32'h0000_0002, "status_done");

        // RESULT byte strobes and back-to-back reads
        wr(8'h10, 4'b0101, 32'h1234_5678, "result_wr");
        rd(8'h10, 32'h0034_0078, "result_rd");
        rd(8'h12, 32'h0034_0078, "b2b_result");
        rd(8'h08, 32'h0000_0003, "b2b_ctrl");
        rd(8'h00, 32'h0000_0000, "b2b_txdata");

        // EXIT: full-word write regardless of strobes, sticky valid
        wr(8'h20, 4'b0000, 32'h0000_0000, "exit0");
        chk("exit0_valid", 32'(exit_valid_o), 32'h1);
        chk("exit0_code", exit_code_o, 32'h0);
        wr(8'h20, 4'b0001, 32'h0000_0005, "exit5");
        chk("exit5_valid", 32'(exit_valid_o), 32'h1);
        chk("exit5_code", exit_code_o, 32'h5);
        rd(8'h20, 32'h0000_0005, "exit_rd");

        // Unmapped offset
        chk("err_idle", 32'(err_o), 32'h0);
        rd(8'h3C, 32'hDEAD_BEEF, "unmapped_rd");
        chk("err_rd_pulse", 32'(err_o), 32'h1);
        @(posedge clk_i);
        #1;
        chk("err_rd_clear", 32'(err_o), 32'h0);
        wr(8'h3C, 4'b1111, 32'hFFFF_FFFF, "unmapped_wr");
        chk("err_wr_pulse", 32'(err_o), 32'h1);
        rd(8'h10, 32'h0034_0078, "unmapped_no_effect");
        chk("err_wr_clear", 32'(err_o), 32'h0);

        // FIFO fill: byte 0 is popped into a 2560-cycle frame, 8 more fill the FIFO
        wr(8'h08, 4'b0011, 32'h0000_00FF, "ctrl255");
        bus_op(1'b1, 8'h00, 4'b0001, 32'h0000_00A0, 32'h0, "fill0", st, stamp0);
        chk("fill0_ready", 32'(st), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            bus_op(1'b1, 8'h00, 4'b0001, 32'(8'hA0 + i), 32'h0, $sformatf("fill%0d", i),
                   st, stamp10);
            chk($sformatf("fill%0d_ready", i), 32'(st), 32'h0);
        end
        rd(8'h04, 32'h0000_0805, "status_full");
        bus_op(1'b1, 8'h00, 4'b0001, 32'h0000_00B0, 32'h0, "fill_over", st, stamp10);
        chk("fill_over_stalled", 32'(st > 0), 32'h1);
        chk("fill_over_accept_cycle", 32'(stamp10 - stamp0), 32'd2563);
        rd(8'h04, 32'h0000_0805, "status_refull");
        do_reset();

        // Reset mid-DATA with three bytes queued
        wr(8'h08, 4'b0011, 32'h0000_0003, "ctrl3b");
        for (int i = 0; i < 4; i++) wr(8'h00, 4'b0001, 32'h0, $sformatf("q%0d", i));
        rd(8'h04, 32'h0000_0304, "status_queued");
        repeat (6) @(posedge clk_i);
        #1;
        chk("tx_data_low", 32'(tx_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rstmid_tx", 32'(tx_o), 32'h1);
        chk("rstmid_exit_valid", 32'(exit_valid_o), 32'h0);
        chk("rstmid_exit_code", exit_code_o, 32'h0);
        chk("rstmid_rdata", rdata_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        rd(8'h04, 32'h0000_0002, "rstmid_status");
        rd(8'h08, 32'h0000_0363, "rstmid_ctrl");
        rd(8'h10, 32'h0000_0000, "rstmid_result");
        repeat (20) @(posedge clk_i);
        #1;
        chk("rstmid_tx_stays_idle", 32'(tx_o), 32'h1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk_i);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
